lsq_dcache_port: RTL

- Processor-side initiator for the data-cache request/response protocol.
- Accepts load/store requests from the LSQ through a valid/ready handshake and drives them onto the dcache's proc2Dcache_* inputs, one per cycle.
- Decodes the dcache's hit, miss-ticket and fill responses.
- Tracks outstanding miss tickets so that late fills are returned to the LSQ with the original load ID.

---
 rtl/lsq_dcache_port_pkg.sv | 20 ++
 rtl/lsq_dcache_port_if.sv | 44 ++++
 rtl/lsq_dcache_port_ticket_table.sv | 57 +++++
 rtl/lsq_dcache_port.sv | 115 +++++++++++
 4 files changed

// File: rtl/lsq_dcache_port_pkg.sv
// Shared bus command encodings, ticket geometry and the issue-register payload
// for the LSQ-to-dcache request port.
package lsq_dcache_port_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int TICKET_W    = 4;
  localparam int NUM_TICKETS = 16;

  typedef logic [TICKET_W-1:0] ticket_t;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
  } bus_req_t;

endpackage

// File: rtl/lsq_dcache_port_if.sv
// Bundle of LSQ handshake, dcache request/response and completion signals.
// The port itself is the master; the LSQ plus dcache environment is the slave.
interface lsq_dcache_port_if #(parameter int LQ_ID_BITS = 3);

  logic                                     req_valid;
  logic                                     req_ready;
  logic [1:0]                               req_cmd;
  logic [63:0]                              req_addr;
  logic [63:0]                              req_data;
  logic [LQ_ID_BITS-1:0]                    req_id;
  logic                                     flush;
  logic [1:0]                               proc2Dcache_command;
  logic [63:0]                              proc2Dcache_addr;
  logic [63:0]                              proc2Dcache_data;
  logic [lsq_dcache_port_pkg::TICKET_W-1:0] Dcache2proc_response;
  logic                                     Dcache2proc_valid;
  logic [lsq_dcache_port_pkg::TICKET_W-1:0] Dcache2proc_tag;
  logic [63:0]                              Dcache2proc_data;
  logic                                     ld_done_valid;
  logic [LQ_ID_BITS-1:0]                    ld_done_id;
  logic [63:0]                              ld_done_data;
  logic                                     st_done_valid;
  logic [LQ_ID_BITS-1:0]                    st_done_id;
  logic [3:0]                               outstanding;
  logic                                     err_dup_ticket;
  logic                                     err_orphan_fill;

  modport master (
    input  req_valid, req_cmd, req_addr, req_data, req_id, flush,
           Dcache2proc_response, Dcache2proc_valid, Dcache2proc_tag, Dcache2proc_data,
    output req_ready, proc2Dcache_command, proc2Dcache_addr, proc2Dcache_data,
           ld_done_valid, ld_done_id, ld_done_data, st_done_valid, st_done_id,
           outstanding, err_dup_ticket, err_orphan_fill
  );

  modport slave (
    output req_valid, req_cmd, req_addr, req_data, req_id, flush,
           Dcache2proc_response, Dcache2proc_valid, Dcache2proc_tag, Dcache2proc_data,
    input  req_ready, proc2Dcache_command, proc2Dcache_addr, proc2Dcache_data,
           ld_done_valid, ld_done_id, ld_done_data, st_done_valid, st_done_id,
           outstanding, err_dup_ticket, err_orphan_fill
  );

endinterface

// File: rtl/lsq_dcache_port_ticket_table.sv
// Miss-ticket table: one {valid, squashed, id} entry per dcache ticket,
// with a same-cycle free-then-allocate ordering and a flush squash.
module dcache_ticket_table
  import lsq_dcache_port_pkg::*;
#(
  parameter int LQ_ID_BITS = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc_en,
  input  ticket_t                alloc_idx,
  input  logic [LQ_ID_BITS-1:0]  alloc_id,
  input  logic                   free_en,
  input  ticket_t                free_idx,
  input  logic                   squash_all,
  input  ticket_t                lookup_idx,
  output logic                   lookup_valid,
  output logic                   lookup_squashed,
  output logic [LQ_ID_BITS-1:0]  lookup_id,
  output logic [NUM_TICKETS-1:0] valid_vec
);

  logic [NUM_TICKETS-1:0] valid;
  logic [NUM_TICKETS-1:0] squashed;
  logic [LQ_ID_BITS-1:0]  ids [NUM_TICKETS];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid    <= '0;
      squashed <= '0;
    end else begin
      for (int i = 0; i < NUM_TICKETS; i++) begin
        if (free_en && free_idx == ticket_t'(i)) begin
          valid[i]    <= 1'b0;
          squashed[i] <= 1'b0;
        end else if (squash_all && valid[i]) begin
          squashed[i] <= 1'b1;
        end
        // Allocation is applied last so it wins over a free of the same ticket.
        if (alloc_en && alloc_idx == ticket_t'(i)) begin
          valid[i]    <= 1'b1;
          squashed[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_en) ids[alloc_idx] <= alloc_id;
  end

  assign lookup_valid    = valid[lookup_idx];
  assign lookup_squashed = squashed[lookup_idx];
  assign lookup_id       = ids[lookup_idx];
  assign valid_vec       = valid;

endmodule

// File: rtl/lsq_dcache_port.sv
// LSQ-side dcache initiator: single issue register, combinational response
// decode, miss-ticket tracking with flush squash, and sticky protocol errors.
module lsq_dcache_port
  import lsq_dcache_port_pkg::*;
#(
  parameter int LQ_ID_BITS      = 3,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic               clock,
  input logic               reset,
  lsq_dcache_port_if.master bus
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic                  iss_vld_p0;
  bus_req_t              iss_req_p0;
  logic [LQ_ID_BITS-1:0] iss_id_p0;
  logic [3:0]            cnt;
  logic                  err_dup, err_orph;

  logic drive, is_load, hit_tag, resp_nz, hit, miss, st_done, complete;
  logic ready, fire, fill, fill_live, fill_deliver, orphan, dup;
  logic                   lk_valid, lk_sq;
  logic [LQ_ID_BITS-1:0]  lk_id;
  logic [NUM_TICKETS-1:0] valid_vec;
  ticket_t                resp_t, tag_t;

  function automatic logic [3:0] sat_count(input logic [3:0] cur, input logic inc,
                                           input logic dec);
    logic signed [5:0] nxt;
    nxt = $signed({2'b00, cur}) + $signed({5'd0, inc}) - $signed({5'd0, dec});
    if (nxt > 6'sd15)     nxt = 6'sd15;
    else if (nxt < 6'sd0) nxt = 6'sd0;
    return nxt[3:0];
  endfunction

  assign resp_t = bus.Dcache2proc_response;
  assign tag_t  = bus.Dcache2proc_tag;

  always_comb begin
    drive   = iss_vld_p0 && !reset;
    is_load = iss_req_p0.cmd == BUS_LOAD;
    hit_tag = bus.Dcache2proc_valid && tag_t == '0;
    resp_nz = resp_t != '0;
    // A flush squashes whatever is being driven, so nothing completes this cycle.
    hit      = drive && !bus.flush && is_load && hit_tag;
    miss     = drive && !bus.flush && is_load && !hit_tag && resp_nz;
    st_done  = drive && !bus.flush && !is_load && (resp_nz || hit_tag);
    complete = hit || miss || st_done;

    fill         = !reset && bus.Dcache2proc_valid && tag_t != '0;
    fill_live    = fill && lk_valid && cnt != 4'd0;
    fill_deliver = fill_live && !lk_sq && !bus.flush;
    orphan       = fill && !fill_live;
    dup          = miss && valid_vec[resp_t] && !(fill_live && tag_t == resp_t);

    ready = !iss_vld_p0 && !reset && !bus.flush &&
            (bus.req_cmd != BUS_LOAD || cnt < MAX_CNT);
    fire  = bus.req_valid && ready;
  end

  // Issue stage: request captured here and driven to the dcache next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      iss_vld_p0 <= 1'b0;
      cnt        <= 4'd0;
      err_dup    <= 1'b0;
      err_orph   <= 1'b0;
    end else begin
      if (bus.flush || complete) iss_vld_p0 <= 1'b0;
      else if (fire)             iss_vld_p0 <= 1'b1;
      cnt <= sat_count(cnt, miss, fill_live);
      if (dup)    err_dup  <= 1'b1;
      if (orphan) err_orph <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fire) begin
      iss_req_p0 <= '{cmd: bus.req_cmd, addr: bus.req_addr, data: bus.req_data};
      iss_id_p0  <= bus.req_id;
    end
  end

  dcache_ticket_table #(.LQ_ID_BITS(LQ_ID_BITS)) u_table (
    .clock           (clock),
    .reset           (reset),
    .alloc_en        (miss),
    .alloc_idx       (resp_t),
    .alloc_id        (iss_id_p0),
    .free_en         (fill_live),
    .free_idx        (tag_t),
    .squash_all      (bus.flush && !reset),
    .lookup_idx      (tag_t),
    .lookup_valid    (lk_valid),
    .lookup_squashed (lk_sq),
    .lookup_id       (lk_id),
    .valid_vec       (valid_vec)
  );

  assign bus.req_ready           = ready;
  assign bus.proc2Dcache_command = drive ? iss_req_p0.cmd  : BUS_NONE;
  assign bus.proc2Dcache_addr    = drive ? iss_req_p0.addr : '0;
  assign bus.proc2Dcache_data    = drive ? iss_req_p0.data : '0;
  assign bus.ld_done_valid       = hit || fill_deliver;
  assign bus.ld_done_id          = hit ? iss_id_p0 : (fill_deliver ? lk_id : '0);
  assign bus.ld_done_data        = (hit || fill_deliver) ? bus.Dcache2proc_data : '0;
  assign bus.st_done_valid       = st_done;
  assign bus.st_done_id          = st_done ? iss_id_p0 : '0;
  assign bus.outstanding         = cnt;
  assign bus.err_dup_ticket      = err_dup;
  assign bus.err_orphan_fill     = err_orph;

endmodule
